bus_arbiter_driver: RTL

Parametrised successor to the single-enable tristate driver: arbitrates N sources onto one shared tristate data bus. Round-robin grant, per-grant hold limit, and a programmable turnaround gap of high-impedance cycles between different owners. Sits between datapath sources (ALU, register file, memory read port) and the shared CPU data bus.

---
 rtl/bus_arbiter_driver_pkg.sv | 16 +
 rtl/bus_arbiter_driver_rr_pick.sv | 32 +++
 rtl/bus_arbiter_driver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_driver_pkg.sv
// Shared definitions for the N-source tristate bus arbiter: FSM states and
// the width helper used for owner index and counters.
package bus_arbiter_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // $clog2 with a floor of 1 bit so degenerate counters still have a width
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_driver_rr_pick.sv
// Round-robin picker: first eligible requester scanning ptr, ptr+1, ... mod N.
module bus_arbiter_driver_rr_pick #(
    parameter int N_SRC = 4,
    parameter int OW    = 2
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [N_SRC-1:0] i_mask,
    input  logic [OW-1:0]    i_ptr,
    output logic             o_found,
    output logic [OW-1:0]    o_idx
);

    logic [N_SRC-1:0] w_elig;

    assign w_elig = i_req & ~i_mask;

    always_comb begin
        int j;
        j       = 0;
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N_SRC) j = j - N_SRC;
            if (!o_found && j < N_SRC && w_elig[j]) begin
                o_found = 1'b1;
                o_idx   = OW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_driver.sv
// Arbitrates N_SRC sources onto one tristate data bus: round-robin grant,
// per-grant hold limit, and TURN_CYCLES high-Z cycles between owners.
module bus_arbiter_driver
    import bus_arbiter_driver_pkg::*;
#(
    parameter int  DATA_WIDTH  = 8,
    parameter int  N_SRC       = 4,
    parameter int  TURN_CYCLES = 1,
    parameter int  MAX_HOLD    = 8,
    localparam int OW          = cnt_w(N_SRC)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_SRC-1:0]            i_req,
    input  logic [N_SRC*DATA_WIDTH-1:0] i_data_in,
    output logic [N_SRC-1:0]            o_grant,
    output logic [OW-1:0]               o_owner_id,
    output logic                        o_bus_valid,
    output logic [DATA_WIDTH-1:0]       o_bus_out
);

    localparam int HW = cnt_w(MAX_HOLD + 1);
    localparam int TW = cnt_w(TURN_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

    state_t            r_state, w_state_nx;
    logic [OW-1:0]     r_owner, w_owner_nx;
    logic [OW-1:0]     r_rr_ptr, w_ptr_nx;
    logic [HW-1:0]     r_hold_cnt, w_hold_nx;
    logic [TW-1:0]     r_turn_cnt, w_turn_nx;
    logic [N_SRC-1:0]  r_grant;
    logic              r_bus_valid;

    logic [N_SRC-1:0]  w_owner_oh;
    logic              w_others;
    logic              w_release;
    logic [OW-1:0]     w_next_ptr;
    logic [OW-1:0]     w_pick_ptr;
    logic [N_SRC-1:0]  w_pick_mask;
    logic              w_found;
    logic [OW-1:0]     w_idx;

    assign w_owner_oh = N_SRC'(1) << r_owner;
    assign w_others   = |(i_req & ~w_owner_oh);
    assign w_next_ptr = (r_owner == OW'(N_SRC - 1)) ? '0 : r_owner + OW'(1);

    // ">=" rather than "==" so a saturated lone owner still yields once a
    // competitor shows up; otherwise it could starve everyone else.
    assign w_release = (r_state == ST_DRIVE) &&
                       (!i_req[r_owner] || ((r_hold_cnt >= HOLD_LIM) && w_others));

    // At a release the outgoing owner is masked and scanning starts after it
    assign w_pick_ptr  = (r_state == ST_DRIVE) ? w_next_ptr : r_rr_ptr;
    assign w_pick_mask = (r_state == ST_DRIVE) ? w_owner_oh : '0;

    bus_arbiter_driver_rr_pick #(
        .N_SRC (N_SRC),
        .OW    (OW)
    ) u_pick (
        .i_req   (i_req),
        .i_mask  (w_pick_mask),
        .i_ptr   (w_pick_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_ptr_nx   = r_rr_ptr;
        w_hold_nx  = r_hold_cnt;
        w_turn_nx  = r_turn_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nx = ST_DRIVE;
                    w_owner_nx = w_idx;
                    w_hold_nx  = '0;
                end
            end
            ST_DRIVE: begin
                if (w_release) begin
                    w_ptr_nx  = w_next_ptr;
                    w_hold_nx = '0;
                    if (!w_others) begin
                        w_state_nx = ST_IDLE;
                    end else if (TURN_CYCLES > 0) begin
                        w_state_nx = ST_TURN;
                        w_turn_nx  = '0;
                    end else if (w_found) begin
                        w_state_nx = ST_DRIVE;
                        w_owner_nx = w_idx;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else if (r_hold_cnt != HOLD_SAT) begin
                    w_hold_nx = r_hold_cnt + HW'(1);
                end
            end
            ST_TURN: begin
                if (r_turn_cnt == TURN_LAST) begin
                    if (w_found) begin
                        w_state_nx = ST_DRIVE;
                        w_owner_nx = w_idx;
                        w_hold_nx  = '0;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_turn_nx = r_turn_cnt + TW'(1);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_hold_cnt  <= '0;
            r_turn_cnt  <= '0;
            r_grant     <= '0;
            r_bus_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_owner     <= w_owner_nx;
            r_rr_ptr    <= w_ptr_nx;
            r_hold_cnt  <= w_hold_nx;
            r_turn_cnt  <= w_turn_nx;
            r_bus_valid <= (w_state_nx == ST_DRIVE);
            r_grant     <= (w_state_nx == ST_DRIVE) ? (N_SRC'(1) << w_owner_nx) : '0;
        end
    end

    assign o_grant     = r_grant;
    assign o_owner_id  = r_owner;
    assign o_bus_valid = r_bus_valid;
    assign o_bus_out   = r_bus_valid ? i_data_in[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH]
                                     : {DATA_WIDTH{1'bz}};

endmodule
